writeback_unit: RTL and testbench

//  Writeback stage directly upstream of the register file: merges single-cycle ALU results and load

---
 rtl/rv_pkg.sv | 14 +
 rtl/load_extend.sv | 36 +++
 rtl/writeback_unit.sv | 120 ++++++++++++
 tb/tb_writeback_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V definitions for the writeback slice: data width, register
// index width and the load funct3 encodings.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks the addressed byte/half out of an aligned
// memory word and sign- or zero-extends it. Unknown funct3 values fall back
// to a full-word load.
module load_extend
  import rv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   addr_lo,
  input  logic [W-1:0] data,
  output logic [W-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and half-word lanes.
  always_comb begin
    byte_sel = data[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? data[16 +: 16] : data[0 +: 16];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    ext = data;
    case (funct3)
      F3_LB:   ext = {{(W-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(W-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(W-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(W-16){1'b0}}, half_sel};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates loads, buffered ALU results and direct ALU
// results onto the single register-file write port. Loads always win; ALU
// results that cannot be written immediately wait in a small FIFO so they
// retire in acceptance order.
module writeback_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = rv_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [rv_pkg::REG_W-1:0] alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     load_valid,
  input  logic [rv_pkg::REG_W-1:0] load_rd,
  input  logic [XLEN-1:0]          load_data,
  input  logic [2:0]               load_funct3,
  input  logic [1:0]               load_addr_lo,
  output logic                     wr_enable,
  output logic [rv_pkg::REG_W-1:0] wr_addr,
  output logic [XLEN-1:0]          wr_data,
  output logic                     busy
);

  import rv_pkg::*;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [REG_W-1:0] fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;

  logic             full, empty;
  logic             alu_xfer, push, pop;
  logic             sel_valid;
  logic [REG_W-1:0] sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic [XLEN-1:0]  load_ext;

  load_extend #(.W(XLEN)) u_load_extend (
    .funct3  (load_funct3),
    .addr_lo (load_addr_lo),
    .data    (load_data),
    .ext     (load_ext)
  );

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign busy      = !empty;
  // When full, a slot frees up only if the head is popped this cycle.
  assign alu_ready = !full || (!load_valid && !empty);
  assign alu_xfer  = alu_valid && alu_ready;
  assign pop       = !load_valid && !empty;
  // An ALU result goes into the FIFO unless it can bypass straight to the port.
  assign push      = alu_xfer && (load_valid || !empty);

  // Priority mux: load, then FIFO head, then direct ALU bypass.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (load_valid) begin
      sel_valid = 1'b1;
      sel_rd    = load_rd;
      sel_data  = load_ext;
    end else if (!empty) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rptr];
      sel_data  = fifo_data[rptr];
    end else if (alu_xfer) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= alu_rd;
      fifo_data[wptr] <= alu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; x0 writes take their slot but never strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_enable <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        wr_addr <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset values, ALU bypass, load
// extraction, FIFO fill/full/drain ordering, x0 suppression and mid-run reset.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_valid;
  logic [4:0]  load_rd;
  logic [31:0] load_data;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  writeback_unit #(.FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .load_valid   (load_valid),
    .load_rd      (load_rd),
    .load_data    (load_data),
    .load_funct3  (load_funct3),
    .load_addr_lo (load_addr_lo),
    .wr_enable    (wr_enable),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    load_valid = 1'b0; load_rd = '0; load_data = '0;
    load_funct3 = 3'd2; load_addr_lo = 2'd0;

    // Reset state
    step(); step();
    check("rst_wr_enable", 32'(wr_enable), 32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_wr_data",   wr_data,        32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    reset = 1'b0;
    #1;
    check("rst_alu_ready", 32'(alu_ready), 32'd1);

    // 1: direct ALU bypass, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    step();
    alu_valid = 1'b0;
    check("byp_en",   32'(wr_enable), 32'd1);
    check("byp_addr", 32'(wr_addr),   32'd5);
    check("byp_data", wr_data,        32'h1234_5678);
    step();
    check("byp_pulse", 32'(wr_enable), 32'd0);

    // 2: load extraction
    load_valid = 1'b1; load_rd = 5'd7; load_data = 32'h80FF_0000;
    load_funct3 = 3'd0; load_addr_lo = 2'd3;
    step();
    check("lb_en",   32'(wr_enable), 32'd1);
    check("lb_addr", 32'(wr_addr),   32'd7);
    check("lb3",     wr_data,        32'hFFFF_FF80);
    load_funct3 = 3'd4;
    step();
    check("lbu3", wr_data, 32'h0000_0080);
    load_funct3 = 3'd5; load_addr_lo = 2'd2;
    step();
    check("lhu2", wr_data, 32'h0000_80FF);
    load_funct3 = 3'd1; load_addr_lo = 2'd3;
    step();
    check("lh3", wr_data, 32'hFFFF_80FF);
    load_funct3 = 3'd0; load_addr_lo = 2'd2;
    step();
    check("lb2", wr_data, 32'hFFFF_FFFF);
    load_funct3 = 3'd2; load_addr_lo = 2'd3;
    step();
    check("lw", wr_data, 32'h80FF_0000);
    load_funct3 = 3'd7; load_addr_lo = 2'd1;
    step();
    check("f3_7_as_lw", wr_data, 32'h80FF_0000);
    load_data = 32'h1234_5678; load_funct3 = 3'd1; load_addr_lo = 2'd1;
    step();
    check("lh1_low_half", wr_data, 32'h0000_5678);
    load_valid = 1'b0;
    step();
    check("load_idle", 32'(wr_enable), 32'd0);

    // 3: load and ALU together -> ALU results queue; fifth is refused
    load_valid = 1'b1; load_rd = 5'd9; load_data = 32'hCAFE_0000;
    load_funct3 = 3'd2; load_addr_lo = 2'd0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA0 + 32'(i);
      #1;
      check($sformatf("fill_ready_%0d", i), 32'(alu_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
      check($sformatf("fill_load_addr_%0d", i), 32'(wr_addr), 32'd9);
      check($sformatf("fill_load_data_%0d", i), wr_data, 32'hCAFE_0000);
    end
    check("fill_busy", 32'(busy), 32'd1);

    // 4: full, no load -> simultaneous push and pop
    load_valid = 1'b0;
    #1;
    check("full_pop_ready", 32'(alu_ready), 32'd1);
    step();
    alu_valid = 1'b0;
    check("full_pop_en",   32'(wr_enable), 32'd1);
    check("full_pop_addr", 32'(wr_addr),   32'd10);
    check("full_pop_data", wr_data,        32'hA0);
    #1;
    check("full_still_full", 32'(alu_ready), 32'd0 | 32'(!1'b0));
    // drain in acceptance order: 11, 12, 13, then the late-accepted 14
    for (int i = 1; i < 5; i++) begin
      check($sformatf("drain_busy_%0d", i), 32'(busy), 32'd1);
      step();
      check($sformatf("drain_en_%0d", i),   32'(wr_enable), 32'd1);
      check($sformatf("drain_addr_%0d", i), 32'(wr_addr),   32'(10 + i));
      check($sformatf("drain_data_%0d", i), wr_data,        32'hA0 + 32'(i));
    end
    check("drain_empty", 32'(busy), 32'd0);
    step();
    check("drain_idle", 32'(wr_enable), 32'd0);

    // 5: rd==0 handling
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    check("x0_alu_en", 32'(wr_enable), 32'd0);
    load_valid = 1'b1; load_rd = 5'd0;
    step();
    load_valid = 1'b0;
    check("x0_load_en", 32'(wr_enable), 32'd0);
    load_valid = 1'b1; load_rd = 5'd0; alu_valid = 1'b1; alu_rd = 5'd0;
    step();
    check("x0_both_en", 32'(wr_enable), 32'd0);
    load_valid = 1'b0; alu_rd = 5'd4; alu_data = 32'h44;
    step();
    alu_valid = 1'b0;
    check("x0_pop_en", 32'(wr_enable), 32'd0);
    check("x0_pop_busy", 32'(busy), 32'd1);
    step();
    check("after_x0_en",   32'(wr_enable), 32'd1);
    check("after_x0_addr", 32'(wr_addr),   32'd4);
    check("after_x0_data", wr_data,        32'h44);
    check("after_x0_busy", 32'(busy),      32'd0);

    // 6: reset with three entries queued
    load_valid = 1'b1; load_rd = 5'd9; load_data = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hB0 + 32'(i);
      step();
    end
    load_valid = 1'b0; alu_valid = 1'b0;
    check("pre_rst_en",   32'(wr_enable), 32'd1);
    check("pre_rst_busy", 32'(busy),      32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_en",   32'(wr_enable), 32'd0);
    check("async_rst_busy", 32'(busy),      32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_en_%0d", i),   32'(wr_enable), 32'd0);
      check($sformatf("post_rst_busy_%0d", i), 32'(busy),      32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
